booth_mac_sequencer: RTL and testbench

- Sequences the shared radix-4 Booth partial-product generator (PPG) over a stream of signed 8-bit activation/weight pairs.
- Feeds one pair per cycle to the PPG and reduces its four partial products and four negate bits into one product.
- Accumulates the products into a signed dot product and returns the result over a valid/ready handshake.
- Sits between the PE operand feeder and the PE output collector.

---
 rtl/booth_mac_sequencer.sv | 114 +++++++++++
 tb/tb_booth_mac_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_sequencer.sv
// Streams signed 8-bit activation/weight pairs through an external radix-4 Booth
// partial-product generator and accumulates the reduced products into a dot product.
module booth_mac_sequencer #(
  parameter int               MAX_TERMS = 9,
  parameter int               ACC_W     = 19,
  parameter logic [ACC_W-1:0] CORR      = ACC_W'(19'h7A800)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_act,
  input  logic [7:0]       in_wgt,
  input  logic             in_last,
  output logic [7:0]       ppg_multiplicand,
  output logic [7:0]       ppg_multiplier,
  input  logic [10:0]      pp0,
  input  logic [8:0]       pp1,
  input  logic [8:0]       pp2,
  input  logic [8:0]       pp3,
  input  logic             neg0,
  input  logic             neg1,
  input  logic             neg2,
  input  logic             neg3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [3:0]       out_count,
  output logic             out_trunc
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_TERMS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, job_end, hs, in_ready_nxt;
  logic             term_vld, first_q, trunc_q;
  logic [3:0]       cnt, cnt_inc;
  logic [ACC_W-1:0] acc, acc_nxt, term;

  assign accept  = in_valid & in_ready;
  assign hs      = out_valid & out_ready;
  assign cnt_inc = (state == IDLE) ? 4'd1 : cnt + 4'd1;
  assign job_end = in_last | (cnt_inc == MAX_CNT);

  // Reassemble the Booth rows; CORR cancels the sign-extension constants baked into the rows.
  assign term = ACC_W'(pp0)
              + (ACC_W'(pp1) << 2)
              + (ACC_W'(pp2) << 4)
              + (ACC_W'(pp3) << 6)
              + ACC_W'(neg0)
              + (ACC_W'(neg1) << 2)
              + (ACC_W'(neg2) << 4)
              + (ACC_W'(neg3) << 6)
              + CORR;

  assign acc_nxt = (first_q ? '0 : acc) + term;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = job_end ? DRAIN : RUN;
      RUN:     if (accept && job_end) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Leaving DONE spends one cycle in IDLE with in_ready low before accepting again.
  assign in_ready_nxt = (state_nxt == RUN) || (state == IDLE && state_nxt == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      in_ready         <= 1'b0;
      ppg_multiplicand <= '0;
      ppg_multiplier   <= '0;
      term_vld         <= 1'b0;
      first_q          <= 1'b0;
      trunc_q          <= 1'b0;
      cnt              <= '0;
      acc              <= '0;
      out_valid        <= 1'b0;
      out_sum          <= '0;
      out_count        <= '0;
      out_trunc        <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= in_ready_nxt;
      term_vld <= accept;
      if (accept) begin
        ppg_multiplicand <= in_act;
        ppg_multiplier   <= in_wgt;
        first_q          <= (state == IDLE);
        cnt              <= cnt_inc;
        if (job_end) trunc_q <= ~in_last;
      end
      if (term_vld) acc <= acc_nxt;
      if (state == DRAIN) begin
        out_sum   <= acc_nxt;
        out_count <= cnt;
        out_trunc <= trunc_q;
      end
      out_valid <= (state == DONE) & ~hs;
      if (hs) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Directed and swept bench for booth_mac_sequencer: Booth PPG stand-in, a product-sum
// reference model, and a per-cycle result compare with pinned literal results.
module tb_booth_mac_sequencer;
  localparam int MAX_TERMS = 9;
  localparam int ACC_W     = 19;
  localparam int N_LIT     = 7;

  logic             clk = 1'b0, reset = 1'b1;
  logic             in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [7:0]       in_act = '0, in_wgt = '0;
  logic [7:0]       ppg_multiplicand, ppg_multiplier;
  logic [10:0]      pp0;
  logic [8:0]       pp1, pp2, pp3;
  logic             neg0, neg1, neg2, neg3;
  logic             out_valid, out_ready = 1'b1, out_trunc;
  logic [ACC_W-1:0] out_sum;
  logic [3:0]       out_count;

  booth_mac_sequencer #(.MAX_TERMS(MAX_TERMS), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
    .ppg_multiplicand(ppg_multiplicand), .ppg_multiplier(ppg_multiplier),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(neg0), .neg1(neg1), .neg2(neg2), .neg3(neg3),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  // Booth row: {neg, 9-bit ones-complement-selected multiple}
  function automatic logic [9:0] booth_row(input logic [7:0] a, input logic [2:0] trip);
    logic [8:0] sel;
    logic       neg;
    case (trip)
      3'b001, 3'b010, 3'b101, 3'b110: sel = {a[7], a};
      3'b011, 3'b100:                 sel = {a, 1'b0};
      default:                        sel = '0;
    endcase
    neg = trip[2] & ~(trip[1] & trip[0]);
    return {neg, neg ? ~sel : sel};
  endfunction

  logic [9:0] r0, r1, r2, r3;
  assign r0   = booth_row(ppg_multiplicand, {ppg_multiplier[1:0], 1'b0});
  assign r1   = booth_row(ppg_multiplicand, ppg_multiplier[3:1]);
  assign r2   = booth_row(ppg_multiplicand, ppg_multiplier[5:3]);
  assign r3   = booth_row(ppg_multiplicand, ppg_multiplier[7:5]);
  assign pp0  = {~r0[8], r0[8], r0[8], r0[7:0]};
  assign pp1  = {~r1[8], r1[7:0]};
  assign pp2  = {~r2[8], r2[7:0]};
  assign pp3  = {~r3[8], r3[7:0]};
  assign neg0 = r0[9];
  assign neg1 = r1[9];
  assign neg2 = r2[9];
  assign neg3 = r3[9];

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [3:0]       cnt;
    logic             trunc;
    int               due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0, m_sum = 0, m_cnt = 0;

  // Reference model: plain signed product sums, closed on in_last or at MAX_TERMS
  always @(posedge clk) begin
    automatic int   s;
    automatic int   c;
    automatic exp_t e;
    cyc <= cyc + 1;
    if (!reset) begin
      exp_q.delete();
      m_sum <= 0;
      m_cnt <= 0;
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        s = m_sum + $signed(in_act) * $signed(in_wgt);
        c = m_cnt + 1;
        if (in_last || c == MAX_TERMS) begin
          e.sum   = ACC_W'(s);
          e.cnt   = 4'(c);
          e.trunc = !in_last;
          e.due   = cyc + 3;
          exp_q.push_back(e);
          m_sum <= 0;
          m_cnt <= 0;
        end else begin
          m_sum <= s;
          m_cnt <= c;
        end
      end
    end
  end

  localparam logic [ACC_W-1:0] LIT_SUM [N_LIT] =
    '{19'h7FFF1, 19'h24000, 19'h5C480, 19'd30, 19'd9, 19'd3, 19'd43};
  localparam logic [3:0] LIT_CNT [N_LIT] = '{4'd1, 4'd9, 4'd9, 4'd5, 4'd9, 4'd3, 4'd2};
  localparam logic       LIT_TRC [N_LIT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] EDGE_VALS [8] =
    '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h55, 8'h7F};

  int   n_chk = 0, n_fail = 0, res_idx = 0, n_jobs = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Advance to the next falling edge and check the result port against the model
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) fail("unexpected_result");
        else begin
          chk("out_sum", 32'(out_sum), 32'(exp_q[0].sum));
          chk("out_count", 32'(out_count), 32'(exp_q[0].cnt));
          chk("out_trunc", 32'(out_trunc), 32'(exp_q[0].trunc));
          chk("in_ready_while_valid", 32'(in_ready), 32'd0);
          if (!prev_valid) begin
            chk("result_latency", 32'(cyc), 32'(exp_q[0].due));
            if (res_idx < N_LIT) begin
              chk("lit_sum", 32'(out_sum), 32'(LIT_SUM[res_idx]));
              chk("lit_count", 32'(out_count), 32'(LIT_CNT[res_idx]));
              chk("lit_trunc", 32'(out_trunc), 32'(LIT_TRC[res_idx]));
            end
            res_idx++;
          end
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        fail("out_valid_late");
      end
    end
    prev_valid = out_valid;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] w, input logic l);
    int g = 0;
    in_valid = 1'b1;
    in_act   = a;
    in_wgt   = w;
    in_last  = l;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    if (!in_ready) fail("accept_timeout");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!out_valid && g < 50) begin
      tick();
      g++;
    end
    if (!out_valid) fail("result_timeout");
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() > 0 || out_valid) && g < 50) begin
      tick();
      g++;
    end
    if (exp_q.size() > 0 || out_valid) fail("drain_timeout");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_sum"}, 32'(out_sum), 32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
    chk({tag, "_out_trunc"}, 32'(out_trunc), 32'd0);
    chk({tag, "_mcand"}, 32'(ppg_multiplicand), 32'd0);
    chk({tag, "_mplier"}, 32'(ppg_multiplier), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and in_ready release timing
    #2 reset = 1'b0;
    #1 chk_zero("reset");
    tick();
    tick();
    #1 reset = 1'b1;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    // 3 x -5
    send(8'd3, 8'hFB, 1'b1);
    n_jobs++;
    drain();

    // Nine -128 x -128, then nine -128 x 127 (last coincides with MAX_TERMS)
    for (int i = 0; i < 9; i++) send(8'h80, 8'h80, i == 8);
    for (int i = 0; i < 9; i++) send(8'h80, 8'h7F, i == 8);
    n_jobs += 2;
    drain();

    // Bubbles every other cycle, then backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 8'd2, i == 5);
      tick();
    end
    n_jobs++;
    wait_valid();
    repeat (6) begin
      tick();
      chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("hs_out_valid_drop", 32'(out_valid), 32'd0);
    chk("gap_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("idle_in_ready_high", 32'(in_ready), 32'd1);

    // Truncation at MAX_TERMS; trailing pairs form a fresh job
    for (int i = 0; i < 12; i++) send(8'd1, 8'd1, i == 11);
    n_jobs += 2;
    drain();

    // Asynchronous reset mid-job discards the partial sum
    for (int i = 0; i < 4; i++) send(8'd5, 8'd5, 1'b0);
    #2 reset = 1'b0;
    #1 chk_zero("midjob_reset");
    tick();
    tick();
    #1 reset = 1'b1;
    tick();
    send(8'd7, 8'd7, 1'b0);
    send(8'hFE, 8'd3, 1'b1);
    n_jobs++;
    drain();
    chk("directed_results", 32'(res_idx), 32'(n_jobs));

    // Single-term sweeps: every activation against edge weights and vice versa
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < 8; j++) begin
        send(8'(a), EDGE_VALS[j], 1'b1);
        n_jobs++;
      end
    for (int w = 0; w < 256; w++)
      for (int j = 0; j < 8; j++) begin
        send(EDGE_VALS[j], 8'(w), 1'b1);
        n_jobs++;
      end
    drain();

    // Random multi-term jobs with random bubbles, some truncated
    repeat (300) begin
      int   len;
      logic trunc_job;
      len       = $urandom_range(1, 9);
      trunc_job = (len == 9) && ($urandom_range(0, 1) == 1);
      for (int k = 0; k < len; k++) begin
        send(8'($urandom), 8'($urandom), (k == len - 1) && !trunc_job);
        if ($urandom_range(0, 3) == 0) tick();
      end
      n_jobs++;
    end
    drain();

    chk("result_count", 32'(res_idx), 32'(n_jobs));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
